adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Capture sequencer for the two-channel ADC sample stream: board current on ch1, gap voltage on ch2, both signed mV.
- Once armed, it writes decimated sample pairs into a circular capture RAM and watches the selected channel for a level crossing.
- After the crossing it records a fixed number of post-trigger samples, then stops so the host can read a pre/post-trigger discharge waveform.
- Sits between the ADC conversion block and a simple dual-port BRAM; the block drives only the BRAM write port.

Parameters:
ADDR_W, 10, capture RAM address width (depth = 2^ADDR_W)
DATA_W, 16, width of each signed channel sample

Ports:
ad_clk  in  1  ADC sample clock, 65 MHz; one new sample pair every cycle
rst_n  in  1  asynchronous active-low reset
volt_ch1  in  DATA_W  signed board-current sample
volt_ch2  in  DATA_W  signed gap-voltage sample
arm  in  1  single-cycle request to start a capture
abort  in  1  single-cycle request to cancel the capture immediately
trig_sel  in  1  trigger channel: 0 = ch1, 1 = ch2
trig_rising  in  1  crossing direction: 1 = rising, 0 = falling
trig_level  in  DATA_W  signed trigger threshold
decim  in  8  write every (decim+1)-th sample
post_len  in  ADDR_W  number of samples written after the trigger sample
buf_we  out  1  RAM write enable
buf_addr  out  ADDR_W  RAM write address
buf_wdata  out  2*DATA_W  RAM write data, {volt_ch2, volt_ch1}
trig_addr  out  ADDR_W  RAM address holding the trigger sample
busy  out  1  high in ARMED or POST
done  out  1  one-cycle pulse when a capture completes

Behaviour:
- Reset: state IDLE. buf_we, buf_addr, buf_wdata, trig_addr, busy, done, write pointer, decimation counter, post counter and prev_valid all 0.
- States: IDLE=0, ARMED=1, POST=2. busy = (state != IDLE), registered.
- IDLE:
  - arm=1 latches trig_sel, trig_rising, trig_level, decim and post_len.
  - Clears the write pointer, the decimation counter and prev_valid, then moves to ARMED.
  - These configuration inputs are ignored while busy.
- arm while busy is ignored. abort overrides arm in the same cycle.
- Decimation: a "tick" is an edge where the state is ARMED or POST and the decimation counter is 0.
  - Counter counts 0..decim_latched and wraps to 0.
  - With decim=0 every cycle is a tick. The first edge after entering ARMED is always a tick.
- On every tick:
  - buf_we<=1, buf_addr<=wr_ptr, buf_wdata<={volt_ch2, volt_ch1} as sampled at that edge, wr_ptr<=wr_ptr+1 (wraps modulo 2^ADDR_W).
  - Write latency is 1 cycle from input to buf_we/buf_wdata.
  - On non-tick edges buf_we<=0.
- Trigger (ARMED ticks only), with cur = selected channel at the tick and prev = selected channel at the previous tick:
  - Rising: prev_valid and prev < trig_level and cur >= trig_level.
  - Falling: prev_valid and prev > trig_level and cur <= trig_level.
  - Comparisons are signed. prev_valid is set after the first ARMED tick, so the first sample can never trigger.
  - On trigger: trig_addr<=wr_ptr (the address of the sample just written), post_cnt<=post_len.
  - Next state is POST, or IDLE with done=1 if post_len==0.
- POST: each tick writes one sample and decrements post_cnt. The tick with post_cnt==1 writes the final sample, state<=IDLE, done<=1 on that same edge.
- done is high exactly one cycle and is otherwise 0.
- Ring wrap: ARMED writes run indefinitely and overwrite the oldest data. If post_len >= 2^ADDR_W-1 the pre-trigger data is fully overwritten; this is legal and not flagged.
- abort (any state): next edge state<=IDLE, buf_we<=0, done stays 0, trig_addr unchanged.
- Asynchronous reset mid-capture: immediate return to the reset values; no done.

Test Plan:
1. Reset values: assert rst_n=0 mid-POST -> all outputs 0 immediately, state IDLE, no done after release.
2. Rising trigger, ch1:
   - Setup: decim=0, trig_level=100, post_len=4, ramp ch1 -50,0,50,100,150 after arm.
   - Expected: writes at addr 0..4, trig_addr=3 (value 100).
   - Expected: 4 more writes addr 4..7, done on the edge writing addr 7, busy falls with it.
3. Falling trigger, ch2, decim=2:
   - Setup: trig_level=-200, ch2 steps 0 -> -300 at cycle 10.
   - Expected: buf_we high every 3rd cycle only; trigger is taken on the first tick seeing -300.
   - Expected: post_len=2 gives exactly 2 further writes.
4. No first-sample trigger: arm while ch1 is already 500 with level 100 rising -> no trigger until ch1 drops below 100 and re-crosses.
5. Wrap/overwrite:
   - Setup: ADDR_W=4, stay ARMED for 20 ticks then trigger.
   - Expected: buf_addr sequence 0..15,0..3, trig_addr=4 for the 21st write.
6. Control edge cases:
   - abort in POST -> no done, buf_we 0 next cycle.
   - arm+abort in the same IDLE cycle -> stays IDLE.
   - post_len=0 -> done on the trigger tick itself.
   - arm during ARMED -> ignored, wr_ptr continues.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger capture sequencer for the two-channel ADC stream.
// Decimated sample pairs go to a circular BRAM until a level crossing plus post_len samples.
module adc_capture_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                     ad_clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] volt_ch1,
  input  logic signed [DATA_W-1:0] volt_ch2,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_sel,
  input  logic                     trig_rising,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic [7:0]               decim,
  input  logic [ADDR_W-1:0]        post_len,
  output logic                     buf_we,
  output logic [ADDR_W-1:0]        buf_addr,
  output logic [2*DATA_W-1:0]      buf_wdata,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic                     sel_l;
  logic                     rising_l;
  logic signed [DATA_W-1:0] level_l;
  logic [7:0]               decim_l;
  logic [ADDR_W-1:0]        post_len_l;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [7:0]               dec_cnt;
  logic [ADDR_W-1:0]        post_cnt;
  logic                     prev_valid;
  logic signed [DATA_W-1:0] prev_smp;

  logic                     tick;
  logic                     hit;
  logic                     start;
  logic                     done_next;
  logic signed [DATA_W-1:0] cur;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    start      = 1'b0;
    hit        = 1'b0;
    cur        = sel_l ? volt_ch2 : volt_ch1;
    tick       = (state != IDLE) && (dec_cnt == '0);
    if (tick && (state == ARMED) && prev_valid) begin
      if (rising_l) hit = (prev_smp < level_l) && (cur >= level_l);
      else          hit = (prev_smp > level_l) && (cur <= level_l);
    end
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            start      = 1'b1;
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (hit) begin
            if (post_len_l == '0) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = POST;
            end
          end
        end
        POST: begin
          if (tick && (post_cnt == CNT_ONE)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_l      <= 1'b0;
      rising_l   <= 1'b0;
      level_l    <= '0;
      decim_l    <= '0;
      post_len_l <= '0;
      wr_ptr     <= '0;
      dec_cnt    <= '0;
      post_cnt   <= '0;
      prev_valid <= 1'b0;
      prev_smp   <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      trig_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy   <= (state_next != IDLE);
      done   <= done_next;
      buf_we <= tick && !abort;
      if (start) begin
        sel_l      <= trig_sel;
        rising_l   <= trig_rising;
        level_l    <= trig_level;
        decim_l    <= decim;
        post_len_l <= post_len;
        wr_ptr     <= '0;
        dec_cnt    <= '0;
        prev_valid <= 1'b0;
      end else if (state != IDLE) begin
        dec_cnt <= (dec_cnt == decim_l) ? '0 : dec_cnt + 8'd1;
      end
      if (tick && !abort) begin
        buf_addr  <= wr_ptr;
        buf_wdata <= {volt_ch2, volt_ch1};
        wr_ptr    <= wr_ptr + CNT_ONE;
        if (state == ARMED) begin
          prev_smp   <= cur;
          prev_valid <= 1'b1;
        end
        if (state == POST) post_cnt <= post_cnt - CNT_ONE;
      end
      // trigger sample lives at the address written on this same edge
      if (hit && !abort) begin
        trig_addr <= wr_ptr;
        post_cnt  <= post_len_l;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: an arithmetic capture model predicts writes,
// trigger address, busy and done; a negedge monitor compares against the DUT.
module tb_adc_capture_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic                 ad_clk = 1'b0;
  logic                 rst_n  = 1'b0;
  logic signed [DW-1:0] volt_ch1 = '0;
  logic signed [DW-1:0] volt_ch2 = '0;
  logic                 arm = 1'b0, abort = 1'b0, trig_sel = 1'b0, trig_rising = 1'b0;
  logic signed [DW-1:0] trig_level = '0;
  logic [7:0]           decim = '0;
  logic [AW-1:0]        post_len = '0;
  logic                 buf_we, busy, done;
  logic [AW-1:0]        buf_addr, trig_addr;
  logic [2*DW-1:0]      buf_wdata;

  always #5 ad_clk = ~ad_clk;

  adc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ad_clk(ad_clk), .rst_n(rst_n), .volt_ch1(volt_ch1), .volt_ch2(volt_ch2),
    .arm(arm), .abort(abort), .trig_sel(trig_sel), .trig_rising(trig_rising),
    .trig_level(trig_level), .decim(decim), .post_len(post_len),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .trig_addr(trig_addr), .busy(busy), .done(done)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // capture model: mode 0 idle, 1 waiting for crossing, 2 post-trigger
  int m_mode = 0, m_since, m_nw, m_remain, m_sel, m_rise, m_dec, m_post, m_lvl, m_prev;
  bit m_have_prev;
  bit m_we = 0, m_done = 0, m_busy = 0;
  int m_trig = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int cur, addr;
    bit hit;
    m_we   = 0;
    m_done = 0;
    if (abort) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (arm) begin
        m_sel = trig_sel; m_rise = trig_rising; m_lvl = int'(trig_level);
        m_dec = decim; m_post = post_len;
        m_since = 0; m_nw = 0; m_have_prev = 0; m_mode = 1;
      end
    end else begin
      if (m_since % (m_dec + 1) == 0) begin
        addr = m_nw % DEPTH;
        m_nw++;
        m_we = 1;
        exp_q.push_back('{addr, {volt_ch2, volt_ch1}});
        if (m_mode == 1) begin
          cur = m_sel ? int'(volt_ch2) : int'(volt_ch1);
          hit = m_have_prev && (m_rise ? (m_prev < m_lvl && cur >= m_lvl)
                                       : (m_prev > m_lvl && cur <= m_lvl));
          m_prev = cur;
          m_have_prev = 1;
          if (hit) begin
            m_trig = addr;
            if (m_post == 0) begin m_done = 1; m_mode = 0; end
            else begin m_remain = m_post; m_mode = 2; end
          end
        end else begin
          m_remain--;
          if (m_remain == 0) begin m_done = 1; m_mode = 0; end
        end
      end
      m_since++;
    end
    m_busy = (m_mode != 0);
  endtask

  task automatic step();
    @(posedge ad_clk);
    #1;
    if (rst_n) model_edge();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic cfg(input bit sel, input bit rise, input int lvl, input int dc, input int pl);
    trig_sel = sel; trig_rising = rise; trig_level = DW'(lvl);
    decim = 8'(dc); post_len = AW'(pl);
  endtask

  always @(negedge ad_clk) begin
    wr_t e;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("buf_we", buf_we, m_we);
    check("trig_addr", trig_addr, m_trig);
    if (buf_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", buf_addr, buf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("buf_addr", buf_addr, e.addr);
        check("buf_wdata", buf_wdata, e.data);
      end
    end
  end

  initial begin
    int ramp[5] = '{-50, 0, 50, 100, 150};
    int walk;

    // reset values while held
    steps(3);
    check("rst_we", buf_we, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", buf_wdata, 0);
    rst_n = 1'b1;
    steps(2);

    // rising trigger on ch1
    cfg(0, 1, 100, 0, 4);
    volt_ch1 = -16'sd50;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      volt_ch1 = DW'(ramp[i]);
      step();
      if (i == 3) check("t2_trig_addr", trig_addr, 3);
    end
    steps(3);
    check("t2_idle", busy, 0);
    steps(2);

    // falling trigger on ch2 with decimation
    cfg(1, 0, -200, 2, 2);
    volt_ch2 = '0;
    pulse_arm();
    steps(9);
    volt_ch2 = -16'sd300;
    steps(12);

    // armed above level: must drop and re-cross
    cfg(0, 1, 100, 0, 1);
    volt_ch1 = 16'sd500;
    pulse_arm();
    steps(5);
    check("t4_no_first_trig", busy, 1);
    volt_ch1 = 16'sd50;  steps(2);
    volt_ch1 = 16'sd150; steps(3);

    // ring wrap: 20 pre-trigger writes, then trigger at address 4
    cfg(0, 1, 100, 0, 1);
    volt_ch1 = '0;
    pulse_arm();
    steps(20);
    volt_ch1 = 16'sd150;
    step();
    check("t5_trig_addr", trig_addr, 4);
    steps(3);

    // abort in POST
    cfg(0, 1, 100, 0, 8);
    volt_ch1 = '0;
    pulse_arm();
    steps(2);
    volt_ch1 = 16'sd200;
    steps(3);
    abort = 1'b1; step(); abort = 1'b0;
    check("t6_abort_we", buf_we, 0);
    check("t6_abort_busy", busy, 0);
    steps(3);

    // arm + abort together in IDLE
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check("t6_arm_abort", busy, 0);
    steps(2);

    // post_len = 0 completes on the trigger tick
    cfg(0, 1, 100, 0, 0);
    volt_ch1 = '0;
    pulse_arm();
    step();
    volt_ch1 = 16'sd120;
    step();
    check("t6_post0_done", done, 1);
    steps(2);

    // arm during ARMED is ignored, config changes ignored
    cfg(0, 1, 100, 0, 2);
    volt_ch1 = '0;
    pulse_arm();
    steps(3);
    cfg(1, 0, -100, 3, 7);
    pulse_arm();
    steps(3);
    volt_ch1 = 16'sd300;
    steps(5);

    // reset mid-POST
    cfg(0, 1, 100, 0, 10);
    volt_ch1 = '0;
    pulse_arm();
    steps(2);
    volt_ch1 = 16'sd200;
    steps(3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we", buf_we, 0);
    check("rst_mid_addr", buf_addr, 0);
    check("rst_mid_trig", trig_addr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    m_mode = 0; m_we = 0; m_done = 0; m_busy = 0; m_trig = 0;
    exp_q.delete();
    steps(2);
    rst_n = 1'b1;
    steps(5);

    // randomized captures
    for (int c = 0; c < 30; c++) begin
      cfg($urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 400)) - 200,
          $urandom_range(0, 3), $urandom_range(0, DEPTH - 1));
      walk = int'($urandom_range(0, 400)) - 200;
      pulse_arm();
      for (int k = 0; k < 120; k++) begin
        walk = walk + int'($urandom_range(0, 160)) - 80;
        if (walk > 600) walk = 600;
        if (walk < -600) walk = -600;
        if ($urandom_range(0, 1) == 1) volt_ch1 = DW'(walk);
        else volt_ch2 = DW'(walk);
        if ($urandom_range(0, 7) == 0)
          cfg($urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 400)) - 200,
              $urandom_range(0, 3), $urandom_range(0, DEPTH - 1));
        arm   = ($urandom_range(0, 29) == 0);
        abort = ($urandom_range(0, 149) == 0);
        step();
      end
      arm = 1'b0;
      abort = 1'b1; step(); abort = 1'b0;
      steps(2);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
